// File: rtl/regfile_sb.sv
// regfile_sb -- architectural register file with per-register scoreboard.
//
// Holds NREGS registers of DATA_W bits with register 0 hard-wired to zero.
// Each nonzero register has a busy bit: it is set when an instruction that
// targets the register issues and cleared when that register is written
// back. A registered count of set busy bits and a one-cycle pulse flagging
// writebacks to non-busy registers are also provided.
//
// Optional feature: define REGFILE_SB_BYPASS_EN to forward same-cycle
// writeback data (and a cleared busy flag) to the read ports. Without the
// macro, reads return stored state only, and writes become visible on the
// following cycle.
//
// Ports:
//   clk                  in   clock, all state updates on rising edge
//   rst                  in   synchronous active-high reset
//   src1, src2           in   read addresses (AW)
//   src1_val, src2_val   out  combinational read data (DATA_W)
//   src1_busy, src2_busy out  busy bit of the addressed register
//   we_reg               in   writeback enable
//   tgt                  in   writeback address (AW)
//   write_data           in   writeback data (DATA_W)
//   issue_valid          in   an instruction targeting issue_tgt issued
//   issue_tgt            in   destination of the issued instruction (AW)
//   busy_cnt             out  registered count of set busy bits (AW+1)
//   wb_orphan            out  registered pulse: writeback to non-busy reg
module regfile_sb #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     src1,
  input  logic [AW-1:0]     src2,
  output logic [DATA_W-1:0] src1_val,
  output logic [DATA_W-1:0] src2_val,
  output logic              src1_busy,
  output logic              src2_busy,
  input  logic              we_reg,
  input  logic [AW-1:0]     tgt,
  input  logic [DATA_W-1:0] write_data,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_tgt,
  output logic [AW:0]       busy_cnt,
  output logic              wb_orphan
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [AW:0]       busy_cnt_q, busy_cnt_d;
  logic              wb_orphan_q, wb_orphan_d;

  logic wr_en;
  logic iss_en;

  // Population count of the next busy vector; registering it keeps busy_cnt
  // in lock-step with the busy bits and bounded by NREGS-1 (bit 0 is never set).
  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + (AW+1)'(v[i]);
    end
    return c;
  endfunction

  assign wr_en  = we_reg && (tgt != '0);
  assign iss_en = issue_valid && (issue_tgt != '0);

  always_comb begin
    busy_d = busy_q;
    // Clear first, then set, so a same-register issue+writeback stays busy.
    if (wr_en) begin
      busy_d[tgt] = 1'b0;
    end
    if (iss_en) begin
      busy_d[issue_tgt] = 1'b1;
    end
    busy_d[0]   = 1'b0;
    busy_cnt_d  = popcount(busy_d);
    wb_orphan_d = wr_en && !busy_q[tgt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      busy_cnt_q  <= '0;
      wb_orphan_q <= 1'b0;
    end else begin
      if (wr_en) begin
        regs_q[tgt] <= write_data;
      end
      busy_q      <= busy_d;
      busy_cnt_q  <= busy_cnt_d;
      wb_orphan_q <= wb_orphan_d;
    end
  end

  // Write-through match per read port.
  logic byp1, byp2;

`ifdef REGFILE_SB_BYPASS_EN
  assign byp1 = wr_en && (tgt == src1);
  assign byp2 = wr_en && (tgt == src2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    src1_val  = '0;
    src2_val  = '0;
    src1_busy = 1'b0;
    src2_busy = 1'b0;
    if (src1 != '0) begin
      src1_val  = byp1 ? write_data : regs_q[src1];
      src1_busy = byp1 ? 1'b0 : busy_q[src1];
    end
    if (src2 != '0) begin
      src2_val  = byp2 ? write_data : regs_q[src2];
      src2_busy = byp2 ? 1'b0 : busy_q[src2];
    end
  end

  assign busy_cnt  = busy_cnt_q;
  assign wb_orphan = wb_orphan_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb. The driver pushes the expected outputs of
// each checked cycle into a queue; a monitor on the falling edge pops and
// compares the fields selected by each entry's mask.
module tb_regfile_sb;

  localparam int DW = 16;
  localparam int N  = 8;
  localparam int A  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [A-1:0]  src1, src2, tgt, issue_tgt;
  logic [DW-1:0] src1_val, src2_val, write_data;
  logic          src1_busy, src2_busy, we_reg, issue_valid, wb_orphan;
  logic [A:0]    busy_cnt;

  regfile_sb #(.DATA_W(DW), .NREGS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .src1       (src1),
    .src2       (src2),
    .src1_val   (src1_val),
    .src2_val   (src2_val),
    .src1_busy  (src1_busy),
    .src2_busy  (src2_busy),
    .we_reg     (we_reg),
    .tgt        (tgt),
    .write_data (write_data),
    .issue_valid(issue_valid),
    .issue_tgt  (issue_tgt),
    .busy_cnt   (busy_cnt),
    .wb_orphan  (wb_orphan)
  );

  always #5 clk = ~clk;

  // mask bits: 0 v1, 1 v2, 2 b1, 3 b2, 4 cnt, 5 orphan
  typedef struct {
    logic [5:0]    m;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
    logic          b1;
    logic          b2;
    logic [A:0]    cnt;
    logic          orph;
    int            id;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc_id = 0;

  task automatic expect_out(input logic [5:0] m, input logic [DW-1:0] v1,
                            input logic [DW-1:0] v2, input logic b1,
                            input logic b2, input logic [A:0] cnt,
                            input logic orph);
    exp_t e;
    e.m = m; e.v1 = v1; e.v2 = v2; e.b1 = b1; e.b2 = b2;
    e.cnt = cnt; e.orph = orph; e.id = cyc_id;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic iv, input logic [A-1:0] it,
                       input logic we, input logic [A-1:0] t,
                       input logic [DW-1:0] wd, input logic [A-1:0] s1,
                       input logic [A-1:0] s2);
    rst = r; issue_valid = iv; issue_tgt = it;
    we_reg = we; tgt = t; write_data = wd; src1 = s1; src2 = s2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_id++;
  endtask

  task automatic cmp(input string name, input int id, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: compares the outputs presented in each checked cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      if (x.m[0]) cmp("src1_val",  x.id, src1_val, x.v1);
      if (x.m[1]) cmp("src2_val",  x.id, src2_val, x.v2);
      if (x.m[2]) cmp("src1_busy", x.id, DW'(src1_busy), DW'(x.b1));
      if (x.m[3]) cmp("src2_busy", x.id, DW'(src2_busy), DW'(x.b2));
      if (x.m[4]) cmp("busy_cnt",  x.id, DW'(busy_cnt), DW'(x.cnt));
      if (x.m[5]) cmp("wb_orphan", x.id, DW'(wb_orphan), DW'(x.orph));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fill[6] = '{1, 2, 4, 5, 6, 7};
    drive(1, 0, 0, 0, 0, 16'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    // Reset must override simultaneous writeback and issue.
    drive(1, 1, 3, 1, 3, 16'h3333, 0, 0);
    tick();

    // Post-reset reads.
    drive(0, 0, 0, 0, 0, 16'h0, 3, 7);
    expect_out(6'h3F, 16'h0, 16'h0, 0, 0, 0, 0);
    tick();

    // Issue to 5, then write it back.
    drive(0, 1, 5, 0, 0, 16'h0, 0, 0);
    expect_out(6'h10, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 5, 0);
    expect_out(6'h15, 16'h0, 0, 1, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 5, 16'hBEEF, 5, 0);
`ifdef REGFILE_SB_BYPASS_EN
    expect_out(6'h15, 16'hBEEF, 0, 0, 0, 1, 0);
`else
    expect_out(6'h15, 16'h0, 0, 1, 0, 1, 0);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 5, 0);
    expect_out(6'h35, 16'hBEEF, 0, 0, 0, 0, 0);
    tick();

    // Issue 2, then simultaneous issue + writeback on 2 (set wins).
    drive(0, 1, 2, 0, 0, 16'h0, 0, 0);
    expect_out(6'h10, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 2, 1, 2, 16'h1234, 2, 0);
`ifdef REGFILE_SB_BYPASS_EN
    expect_out(6'h35, 16'h1234, 0, 0, 0, 1, 0);
`else
    expect_out(6'h35, 16'h0, 0, 1, 0, 1, 0);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 2, 0);
    expect_out(6'h35, 16'h1234, 0, 1, 0, 1, 0);
    tick();

    // Register 0: writes and issues ignored.
    drive(0, 1, 0, 1, 0, 16'hFFFF, 0, 0);
    expect_out(6'h15, 16'h0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 0, 0);
    expect_out(6'h35, 16'h0, 0, 0, 0, 1, 0);
    tick();

    // Orphan writeback to non-busy register 4.
    drive(0, 0, 0, 1, 4, 16'h4444, 0, 4);
`ifdef REGFILE_SB_BYPASS_EN
    expect_out(6'h22, 0, 16'h4444, 0, 0, 0, 0);
`else
    expect_out(6'h22, 0, 16'h0, 0, 0, 0, 0);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 0, 4);
    expect_out(6'h32, 0, 16'h4444, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 0, 0);
    expect_out(6'h20, 0, 0, 0, 0, 0, 0);
    tick();

    // Set on 3 and clear on 2 in the same cycle: net zero.
    drive(0, 1, 6, 0, 0, 16'h0, 0, 0);
    expect_out(6'h10, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 1, 3, 1, 2, 16'h2222, 0, 6);
    expect_out(6'h18, 0, 0, 0, 1, 2, 0);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 2, 6);
    expect_out(6'h3D, 16'h2222, 0, 0, 1, 2, 0);
    tick();

    // Writeback to busy 6 while reading it.
    drive(0, 0, 0, 1, 6, 16'h00A5, 0, 6);
`ifdef REGFILE_SB_BYPASS_EN
    expect_out(6'h1A, 0, 16'h00A5, 0, 0, 2, 0);
`else
    expect_out(6'h1A, 0, 16'h0, 0, 1, 2, 0);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 0, 6);
    expect_out(6'h3A, 0, 16'h00A5, 0, 0, 1, 0);
    tick();

    // Re-issue to already-busy 3 leaves count unchanged.
    drive(0, 1, 3, 0, 0, 16'h0, 3, 0);
    expect_out(6'h14, 0, 0, 1, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 3, 0);
    expect_out(6'h14, 0, 0, 1, 0, 1, 0);
    tick();

    // Fill every nonzero register; count saturates at NREGS-1 naturally.
    foreach (fill[i]) begin
      drive(0, 1, A'(fill[i]), 0, 0, 16'h0, 0, 0);
      tick();
    end
    drive(0, 1, 1, 0, 0, 16'h0, 7, 1);
    expect_out(6'h1C, 0, 0, 1, 1, 7, 0);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 7, 0);
    expect_out(6'h14, 0, 0, 1, 0, 7, 0);
    tick();

    // Reset with concurrent activity clears everything.
    drive(1, 1, 1, 1, 2, 16'h5555, 0, 0);
    expect_out(6'h10, 0, 0, 0, 0, 7, 0);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 1, 5);
    expect_out(6'h3F, 16'h0, 16'h0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 2, 4);
    expect_out(6'h0F, 16'h0, 16'h0, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
